dmem_run_ctrl: RTL and testbench

//  Run controller and data-memory owner for the single-cycle core. Lets a host port preload
//  and dump data_memory while the core is stopped, pulses the core's start, hands memory to
//  the core while it runs, and detects halt or timeout. Reports the run length in cycles.

---
 rtl/dmem_ctl_pkg.sv | 30 +++
 rtl/dmem_run_ctrl_if.sv | 54 +++++
 rtl/run_cycle_counter.sv | 45 ++++
 rtl/dmem_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_dmem_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctl_pkg.sv
// ============================================================================
// Module      : dmem_ctl_pkg
// Description : Shared types and default widths for the data-memory run
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_ctl_pkg;

  localparam int unsigned c_aw = 8;
  localparam int unsigned c_dw = 8;
  localparam int unsigned c_cw = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_TOUT   = 3'd4
  } run_state_e;

  // The host owns data memory whenever the core is neither launching nor running.
  function automatic logic host_owns(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TOUT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_run_ctrl_if.sv
// ============================================================================
// Module      : dmem_run_ctrl_if
// Description : Host, core and data-memory signal bundle of the run controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_run_ctrl_if
  import dmem_ctl_pkg::*;
#(
  parameter int unsigned AW = c_aw,
  parameter int unsigned DW = c_dw,
  parameter int unsigned CW = c_cw
);
  logic          host_go;
  logic          host_req;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          core_start;
  logic          core_halt;
  logic          core_wr_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          dm_wr_en;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  modport slave (
    input  host_go, host_req, host_wr_en, host_addr, host_wdata,
    input  core_halt, core_wr_en, core_addr, core_wdata, dm_rdata,
    output host_gnt, host_rvalid, host_rdata, core_start, core_rdata,
    output dm_wr_en, dm_addr, dm_wdata, busy, done, timeout, cycle_count
  );

  modport master (
    output host_go, host_req, host_wr_en, host_addr, host_wdata,
    output core_halt, core_wr_en, core_addr, core_wdata, dm_rdata,
    input  host_gnt, host_rvalid, host_rdata, core_start, core_rdata,
    input  dm_wr_en, dm_addr, dm_wdata, busy, done, timeout, cycle_count
  );

endinterface

`default_nettype wire

// File: rtl/run_cycle_counter.sv
// ============================================================================
// Module      : run_cycle_counter
// Description : Run-length counter with clear/enable and a look-ahead flag
//               that fires on the increment reaching MAX_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_cycle_counter
  import dmem_ctl_pkg::*;
#(
  parameter int unsigned CW         = c_cw,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFF0
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] c_last = CW'(MAX_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;

  assign w_next   = r_count + CW'(1);
  // >= keeps MAX_CYCLES=1 from wrapping: the first increment already hits the limit.
  assign at_limit = enable && (w_next >= c_last);
  assign count    = r_count;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_run_ctrl.sv
// ============================================================================
// Module      : dmem_run_ctrl
// Description : Run controller and data-memory owner: host preload/dump while
//               stopped, core start pulse, halt/timeout detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_run_ctrl
  import dmem_ctl_pkg::*;
#(
  parameter int unsigned AW         = c_aw,
  parameter int unsigned DW         = c_dw,
  parameter int unsigned CW         = c_cw,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFF0,
  parameter int unsigned START_CYC  = 2
) (
  input  logic           CLK,
  input  logic           Reset,
  dmem_run_ctrl_if.slave bus
);

  localparam int unsigned c_start_w = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  run_state_e           r_state;
  logic [c_start_w-1:0] r_start_cnt;
  logic                 r_core_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_timeout;
  logic                 r_host_rvalid;
  logic [DW-1:0]        r_host_rdata;

  logic          w_host_owns;
  logic          w_run;
  logic          w_host_rd;
  logic          w_launch;
  logic          w_cnt_en;
  logic          w_at_limit;
  logic [CW-1:0] w_cycle_count;
  logic          w_host_gnt;
  logic          w_dm_wr_en;
  logic [AW-1:0] w_dm_addr;
  logic [DW-1:0] w_dm_wdata;

  assign w_host_owns = host_owns(r_state);
  assign w_run       = (r_state == ST_RUN);
  assign w_host_rd   = w_host_owns && bus.host_req && !bus.host_wr_en;
  // A pending host access takes priority over a launch request.
  assign w_launch    = w_host_owns && bus.host_go && !bus.host_req;
  assign w_cnt_en    = w_run && !bus.core_halt;

  run_cycle_counter #(
    .CW         (CW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_cycle_counter (
    .CLK      (CLK),
    .Reset    (Reset),
    .clear    (w_launch),
    .enable   (w_cnt_en),
    .count    (w_cycle_count),
    .at_limit (w_at_limit)
  );

  always_comb begin
    w_host_gnt = 1'b0;
    w_dm_wr_en = 1'b0;
    w_dm_addr  = '0;
    w_dm_wdata = '0;
    if (w_host_owns) begin
      w_host_gnt = bus.host_req;
      w_dm_wr_en = bus.host_req && bus.host_wr_en;
      w_dm_addr  = bus.host_req ? bus.host_addr  : '0;
      w_dm_wdata = bus.host_req ? bus.host_wdata : '0;
    end else if (w_run) begin
      w_dm_wr_en = bus.core_wr_en;
      w_dm_addr  = bus.core_addr;
      w_dm_wdata = bus.core_wdata;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_start_cnt   <= '0;
      r_core_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) begin
        r_host_rdata <= bus.dm_rdata;
      end
      case (r_state)
        ST_IDLE, ST_DONE, ST_TOUT: begin
          if (w_launch) begin
            r_state      <= ST_LAUNCH;
            r_start_cnt  <= c_start_w'(START_CYC - 1);
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          if (r_start_cnt == '0) begin
            r_state      <= ST_RUN;
            r_core_start <= 1'b0;
          end else begin
            r_start_cnt <= r_start_cnt - c_start_w'(1);
          end
        end
        ST_RUN: begin
          if (bus.core_halt) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_at_limit) begin
            r_state   <= ST_TOUT;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_core_start <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.host_gnt    = w_host_gnt;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.core_start  = r_core_start;
  assign bus.core_rdata  = bus.dm_rdata;
  assign bus.dm_wr_en    = w_dm_wr_en;
  assign bus.dm_addr     = w_dm_addr;
  assign bus.dm_wdata    = w_dm_wdata;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = w_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_dmem_run_ctrl.sv
// ============================================================================
// Module      : tb_dmem_run_ctrl
// Description : Self-checking bench for dmem_run_ctrl with a data-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_run_ctrl;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int MAXC = 100;
  localparam int STC  = 2;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  logic mem_init = 1'b1;
  logic cmp_en   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  dmem_run_ctrl_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  dmem_run_ctrl #(
    .AW(AW), .DW(DW), .CW(CW), .MAX_CYCLES(MAXC), .START_CYC(STC)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Environment data memory driven by the DUT's dm_* port
  logic [7:0] env_mem [256];
  assign bus.dm_rdata = env_mem[bus.dm_addr];
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i) ^ 8'h3C;
    end else if (bus.dm_wr_en) begin
      env_mem[bus.dm_addr] <= bus.dm_wdata;
    end
  end

  // Behavioural model: phase 0 idle, 1 launch, 2 run, 3 done, 4 timed out
  int         m_ph, m_left, m_cnt;
  logic       m_done, m_tout, m_rvalid;
  logic [7:0] m_rdata;
  logic [7:0] m_mem [256];

  function automatic logic m_owned();
    return (m_ph == 0) || (m_ph == 3) || (m_ph == 4);
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (mem_init) for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h3C;
    if (Reset) begin
      m_ph = 0; m_left = 0; m_cnt = 0;
      m_done = 0; m_tout = 0; m_rvalid = 0; m_rdata = 0;
    end else begin
      m_rvalid = m_owned() && bus.host_req && !bus.host_wr_en;
      if (m_rvalid) m_rdata = m_mem[bus.host_addr];
      if (m_owned()) begin
        if (bus.host_req && bus.host_wr_en) m_mem[bus.host_addr] = bus.host_wdata;
        else if (!bus.host_req && bus.host_go) begin
          m_ph = 1; m_left = STC; m_cnt = 0; m_done = 0; m_tout = 0;
        end
      end else if (m_ph == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_ph = 2;
      end else begin
        if (bus.core_wr_en) m_mem[bus.core_addr] = bus.core_wdata;
        if (bus.core_halt) begin
          m_ph = 3; m_done = 1;
        end else begin
          m_cnt = m_cnt + 1;
          if (m_cnt >= MAXC - 1) begin m_ph = 4; m_tout = 1; end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("gnt", bus.host_gnt, m_owned() && bus.host_req);
      chk("dm_wr_en", bus.dm_wr_en,
          m_owned() ? (bus.host_req && bus.host_wr_en) : (m_ph == 2) ? bus.core_wr_en : 1'b0);
      chk("core_start", bus.core_start, m_ph == 1);
      chk("busy", bus.busy, (m_ph == 1) || (m_ph == 2));
      chk("done", bus.done, m_done);
      chk("timeout", bus.timeout, m_tout);
      chk("cycle_count", bus.cycle_count, 32'(m_cnt));
      chk("rvalid", bus.host_rvalid, m_rvalid);
      chk("core_rdata", bus.core_rdata, bus.dm_rdata);
      if (m_rvalid) chk("rdata", bus.host_rdata, m_rdata);
      if (m_owned() && bus.host_req) begin
        chk("dm_addr_host", bus.dm_addr, bus.host_addr);
        if (bus.host_wr_en) chk("dm_wdata_host", bus.dm_wdata, bus.host_wdata);
      end
      if (m_ph == 2) begin
        chk("dm_addr_core", bus.dm_addr, bus.core_addr);
        chk("dm_wdata_core", bus.dm_wdata, bus.core_wdata);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Launch, then n halt-free RUN cycles, then optionally one halt cycle
  task automatic run_core(input int n, input bit halt, input bit cw, input bit pend);
    bus.host_go = 1'b1;
    cyc();
    bus.host_go = 1'b0;
    for (int k = 0; k < STC; k++) begin
      @(negedge CLK);
      chk("launch_start", bus.core_start, 1'b1);
      cyc();
    end
    @(negedge CLK);
    chk("run_start_low", bus.core_start, 1'b0);
    for (int i = 0; i < n; i++) begin
      bus.core_wr_en = cw && (i == 5);
      bus.core_addr  = (cw && i == 5) ? 8'h30 : 8'(i);
      bus.core_wdata = 8'h5C;
      bus.host_go    = (i == 7);
      if (pend && i == 3) begin
        bus.host_req = 1'b1; bus.host_wr_en = 1'b1;
        bus.host_addr = 8'h10; bus.host_wdata = 8'hEE;
      end
      cyc();
    end
    bus.core_wr_en = 1'b0;
    bus.host_go    = 1'b0;
    if (halt) begin
      bus.core_halt = 1'b1;
      @(negedge CLK);
      if (pend) begin
        chk("stall_gnt", bus.host_gnt, 1'b0);
        chk("mem_untouched", env_mem[8'h10], 8'hA5);
      end
      cyc();
      bus.core_halt = 1'b0;
    end
  endtask

  initial begin
    bus.host_go = 0; bus.host_req = 0; bus.host_wr_en = 0;
    bus.host_addr = 0; bus.host_wdata = 0;
    bus.core_halt = 0; bus.core_wr_en = 0; bus.core_addr = 0; bus.core_wdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    mem_init = 1'b0;
    @(negedge CLK);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_count", bus.cycle_count, 0);
    chk("rst_start", bus.core_start, 1'b0);
    chk("rst_rvalid", bus.host_rvalid, 1'b0);
    chk("rst_rdata", bus.host_rdata, 0);
    cmp_en = 1'b1;
    cyc();
    Reset = 1'b0;

    // Host write then read-back while idle
    bus.host_req = 1; bus.host_wr_en = 1; bus.host_addr = 8'h10; bus.host_wdata = 8'hA5;
    @(negedge CLK);
    chk("t1_wr_gnt", bus.host_gnt, 1'b1);
    cyc();
    bus.host_wr_en = 0;
    @(negedge CLK);
    chk("t1_rd_gnt", bus.host_gnt, 1'b1);
    cyc();
    bus.host_req = 0;
    @(negedge CLK);
    chk("t1_rvalid", bus.host_rvalid, 1'b1);
    chk("t1_rdata", bus.host_rdata, 8'hA5);

    // Go while a host access is pending is ignored
    bus.host_go = 1; bus.host_req = 1;
    cyc();
    bus.host_go = 0; bus.host_req = 0;
    @(negedge CLK);
    chk("go_ignored_busy", bus.busy, 1'b0);

    // Halt after 40 RUN cycles, with one core store
    run_core(40, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("t2_done", bus.done, 1'b1);
    chk("t2_count", bus.cycle_count, 40);
    chk("t2_busy", bus.busy, 1'b0);
    bus.host_req = 1; bus.host_addr = 8'h30;
    cyc();
    bus.host_req = 0;
    @(negedge CLK);
    chk("t2_core_store", bus.host_rdata, 8'h5C);

    // No halt: timeout
    run_core(120, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("t3_timeout", bus.timeout, 1'b1);
    chk("t3_done", bus.done, 1'b0);
    chk("t3_count", bus.cycle_count, 99);

    // Host write stalled during RUN, granted in first DONE cycle
    run_core(10, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    chk("t4_gnt_done", bus.host_gnt, 1'b1);
    chk("t4_count", bus.cycle_count, 10);
    cyc();
    bus.host_req = 0; bus.host_wr_en = 0;
    @(negedge CLK);
    chk("t4_mem_written", env_mem[8'h10], 8'hEE);

    // Halt on the limit cycle: halt wins
    run_core(98, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("t5_done", bus.done, 1'b1);
    chk("t5_timeout", bus.timeout, 1'b0);
    chk("t5_count", bus.cycle_count, 98);
    bus.host_go = 1; bus.host_req = 1; bus.host_addr = 8'h00;
    cyc();
    bus.host_go = 0; bus.host_req = 0;
    @(negedge CLK);
    chk("t5_go_ignored", bus.busy, 1'b0);

    // Reset mid-RUN
    run_core(10, 1'b0, 1'b0, 1'b0);
    bus.core_wr_en = 1; bus.core_addr = 8'h40; bus.core_wdata = 8'h99;
    Reset = 1'b1;
    @(negedge CLK);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_start", bus.core_start, 1'b0);
    chk("t6_dm_wr", bus.dm_wr_en, 1'b0);
    chk("t6_count", bus.cycle_count, 0);
    cyc();
    Reset = 1'b0;
    bus.core_wr_en = 0;
    bus.host_req = 1; bus.host_addr = 8'h40;
    cyc();
    bus.host_req = 0;
    @(negedge CLK);
    chk("t6_no_store", bus.host_rdata, 8'h7C);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
